// File: rtl/mul_hilo_pkg.sv
// Shared types and widths for the HI/LO multiply sequencer.
// Optional overflow flag is enabled with MUL_HILO_OVF_EN.
package mul_hilo_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    // Product does not fit in a signed word when the top 33 bits are not all equal
    function automatic logic prod_ovf(input logic [PROD_W-1:0] p);
        return !((&p[PROD_W-1:WORD_W-1]) || (~|p[PROD_W-1:WORD_W-1]));
    endfunction

endpackage

// File: rtl/mul_hilo_seq_hilo_reg_pair.sv
// HI/LO product holding registers with load enable and synchronous clear.
module hilo_reg_pair
    import mul_hilo_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic [PROD_W-1:0] prod,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    always_ff @(posedge clock) begin
        if (clear) begin
            hi <= '0;
            lo <= '0;
        end else if (load) begin
            hi <= prod[PROD_W-1:WORD_W];
            lo <= prod[WORD_W-1:0];
        end
    end

endmodule

// File: rtl/mul_hilo_seq.sv
// Sequencer for an external multicycle multiplier: registers operands, waits, captures HI/LO, writes LO then HI.
// Define MUL_HILO_OVF_EN to add the registered ovf output.
module mul_hilo_seq
    import mul_hilo_pkg::*;
#(
    parameter int unsigned MUL_WAIT = 2
)
(
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    output logic [WORD_W-1:0] mul_m,
    output logic [WORD_W-1:0] mul_q,
    input  logic [PROD_W-1:0] mul_p,
    output logic              busy,
    output logic [WORD_W-1:0] bus_out,
    output logic              bus_sel,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              done
`ifdef MUL_HILO_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_WAIT - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             accept_c;
    logic             capture_c;

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and internal strobes
    always_comb begin
        state_n   = state;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = WAIT;
                    accept_c = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n   = WR_LO;
                    capture_c = 1'b1;
                end
            end
            WR_LO: begin
                if (bus_ready) begin
                    state_n = WR_HI;
                end
            end
            WR_HI: begin
                if (bus_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs decoded from the registered state; done follows bus_ready in WR_HI
    always_comb begin
        busy      = 1'b0;
        bus_valid = 1'b0;
        bus_sel   = 1'b0;
        bus_out   = '0;
        done      = 1'b0;
        case (state)
            WAIT: begin
                busy = 1'b1;
            end
            WR_LO: begin
                busy      = 1'b1;
                bus_valid = 1'b1;
                bus_out   = lo;
            end
            WR_HI: begin
                busy      = 1'b1;
                bus_valid = 1'b1;
                bus_sel   = 1'b1;
                bus_out   = hi;
                done      = bus_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand registers hold until the next accepted start; settle counter
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt   <= '0;
            mul_m <= '0;
            mul_q <= '0;
        end else if (accept_c) begin
            cnt   <= CNT_INIT;
            mul_m <= op_a;
            mul_q <= op_b;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    hilo_reg_pair u_hilo (
        .clock (clock),
        .clear (clear),
        .load  (capture_c),
        .prod  (mul_p),
        .hi    (hi),
        .lo    (lo)
    );

`ifdef MUL_HILO_OVF_EN
    // Overflow flag tracks the most recent capture
    always_ff @(posedge clock) begin
        if (clear) begin
            ovf <= 1'b0;
        end else if (capture_c) begin
            ovf <= prod_ovf(mul_p);
        end
    end
`endif

endmodule

// File: tb/tb_mul_hilo_seq.sv
// Scoreboard bench for mul_hilo_seq: directed products, stall, abort and back-to-back timing.
module tb_mul_hilo_seq;

    localparam int unsigned MW = 2;

    typedef struct packed {
        logic        sel;
        logic [31:0] data;
    } beat_t;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mul_m;
    logic [31:0] mul_q;
    logic [63:0] mul_p;
    logic        busy;
    logic [31:0] bus_out;
    logic        bus_sel;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
`ifdef MUL_HILO_OVF_EN
    logic        ovf;
`endif

    int nvec;
    int nerr;
    int cyc;
    int done_prev;
    int done_last;
    beat_t sb[$];

    mul_hilo_seq #(.MUL_WAIT(MW)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_m     (mul_m),
        .mul_q     (mul_q),
        .mul_p     (mul_p),
        .busy      (busy),
        .bus_out   (bus_out),
        .bus_sel   (bus_sel),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .hi        (hi),
        .lo        (lo),
        .done      (done)
`ifdef MUL_HILO_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Stand-in for the external signed multiplier
    logic signed [63:0] ext_m;
    logic signed [63:0] ext_q;
    assign ext_m = 64'($signed(mul_m));
    assign ext_q = 64'($signed(mul_q));
    assign mul_p = ext_m * ext_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pop expected beats on every accepted transfer
    initial begin
        beat_t exp_b;
        forever begin
            @(negedge clock);
            if (!clear) begin
                if (bus_valid && bus_ready) begin
                    if (sb.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_beat: got sel=%0d data=%h expected no beat", bus_sel, bus_out);
                    end else begin
                        exp_b = sb.pop_front();
                        check("beat_sel", 32'(bus_sel), 32'(exp_b.sel));
                        check("beat_data", bus_out, exp_b.data);
                    end
                end
                if (done || (bus_valid && bus_ready && bus_sel)) begin
                    check("done_pulse", 32'(done), 32'(bus_valid && bus_ready && bus_sel));
                end
                if (done) begin
                    done_prev = done_last;
                    done_last = cyc;
                end
            end
        end
    end

    // One transaction with bus_ready high, checking cycle-exact progress
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_ovf);
        sb.push_back('{sel: 1'b0, data: exp_lo});
        sb.push_back('{sel: 1'b1, data: exp_hi});
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("mul_m", mul_m, a);
        check("mul_q", mul_q, b);
        repeat (MW - 1) tick();
        check("wait_no_valid", 32'(bus_valid), 32'd0);
        tick();
        check("wr_lo_valid", 32'(bus_valid), 32'd1);
        check("lo_reg", lo, exp_lo);
        check("hi_reg", hi, exp_hi);
`ifdef MUL_HILO_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) check("ovf_arg", 32'(exp_ovf), 32'd0);
`endif
        tick();
        check("wr_hi_sel", 32'(bus_sel), 32'd1);
        check("wr_hi_done", 32'(done), 32'd1);
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        cyc       = 0;
        done_prev = 0;
        done_last = 0;
        clear     = 1'b1;
        start     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        bus_ready = 1'b1;
        tick();
        tick();
        clear = 1'b0;

        check("rst_mul_m", mul_m, 32'h0);
        check("rst_mul_q", mul_q, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_bus_out", bus_out, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef MUL_HILO_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif

        run_op(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1);

        // Stall in WR_LO with an ignored start
        bus_ready = 1'b0;
        sb.push_back('{sel: 1'b0, data: 32'hFFFF_FFEB});
        sb.push_back('{sel: 1'b1, data: 32'hFFFF_FFFF});
        op_a  = 32'd7;
        op_b  = 32'hFFFF_FFFD;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (MW) tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus_valid), 32'd1);
            check("stall_sel", 32'(bus_sel), 32'd0);
            check("stall_data", bus_out, 32'hFFFF_FFEB);
            start = (i == 2);
            op_a  = 32'd5;
            tick();
        end
        start = 1'b0;
        check("stall_still_lo", 32'(bus_sel), 32'd0);
        bus_ready = 1'b1;
        tick();
        check("stall_release_sel", 32'(bus_sel), 32'd1);
        check("stall_release_data", bus_out, 32'hFFFF_FFFF);
        tick();
        check("stall_idle_busy", 32'(busy), 32'd0);
        check("stall_mul_m_kept", mul_m, 32'd7);
        tick();
        check("stall_start_not_queued", 32'(busy), 32'd0);

        // Abort in WAIT
        op_a  = 32'd3;
        op_b  = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy_before", 32'(busy), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_mul_m", mul_m, 32'h0);
        check("abort_bus_valid", 32'(bus_valid), 32'd0);
        repeat (MW + 2) tick();
        check("abort_no_resume", 32'(bus_valid), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        run_op(32'd2, 32'd3, 32'd6, 32'd0, 1'b0);

        // Back-to-back: second start issued in the first IDLE cycle
        run_op(32'd5, 32'd6, 32'd30, 32'd0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        check("b2b_spacing", 32'(done_last - done_prev), 32'(MW + 3));

        tick();
        tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_hilo_seq.md
# mul_hilo_seq

Sequencer directly downstream of the combinational 32×32 Booth multiplier. Registers the operands that drive the multiplier and waits a fixed number of cycles for its 64-bit product to settle (a declared multicycle path). It then captures the product into HI/LO registers and writes it onto the 32-bit datapath bus over two handshaked beats, LO first and HI second.

## Interface
- MUL_WAIT, 2: cycles allowed for the multiplier to settle; legal range 1–15.
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  32  multiplicand (M), signed.
- op_b  in  32  multiplier (Q), signed.
- mul_m  out  32  registered operand to multiplier M input.
- mul_q  out  32  registered operand to multiplier Q input.
- mul_p  in  64  product returned from multiplier.
- busy  out  1  high in every state except IDLE.
- bus_out  out  32  write data, LO beat then HI beat.
- bus_sel  out  1  0 = LO beat, 1 = HI beat.
- bus_valid  out  1  beat presented.
- bus_ready  in  1  consumer accepts the beat.
- hi  out  32  HI register, persistent.
- lo  out  32  LO register, persistent.
- done  out  1  one-cycle pulse when the HI beat is accepted.
- ovf  out  1  present only with MUL_HILO_OVF_EN.

## Operation
- States: IDLE, WAIT, WR_LO, WR_HI.
- IDLE, start=1:
  - mul_m←op_a, mul_q←op_b.
  - cnt←MUL_WAIT-1.
  - Next state WAIT.
- WAIT:
  - cnt≠0: cnt decrements.
  - cnt==0: hi←mul_p[63:32], lo←mul_p[31:0]; next state WR_LO.
- WR_LO:
  - Outputs: bus_valid=1, bus_sel=0, bus_out=lo.
  - Advances to WR_HI only on a cycle with bus_ready=1; otherwise holds with stable outputs.
- WR_HI:
  - Outputs: bus_valid=1, bus_sel=1, bus_out=hi.
  - On bus_ready=1: done=1 that cycle (combinational), then IDLE.
- start outside IDLE is ignored and not queued.
- Operand changes after acceptance are ignored; mul_m and mul_q hold until the next accepted start.
- hi/lo keep their values after the transaction until the next capture.
- bus_out=0 when bus_valid=0.
- mul_p is treated as 64-bit two's complement. No arithmetic is performed in this block.

## Timing
- Reset values: mul_m, mul_q, hi, lo, bus_out = 0; busy, bus_valid, bus_sel, done, ovf = 0; state=IDLE; cnt=0.
- clear has priority over every other condition in every state. Mid-operation it aborts with no done pulse and no partial writeback.
- Edge E0 accepts start:
  - busy=1 from E0.
  - Capture occurs at edge E(MUL_WAIT).
  - WR_LO is visible after E(MUL_WAIT).
  - With bus_ready held high: WR_HI after E(MUL_WAIT+1), IDLE after E(MUL_WAIT+2).
  - Minimum occupancy: MUL_WAIT+2 cycles.
- mul_p is sampled exactly MUL_WAIT edges after the operands change. The multiplier path must meet MUL_WAIT clock periods.
- start is accepted again in the first IDLE cycle after done, so back-to-back throughput is one product per MUL_WAIT+3 cycles.
- bus_ready held low stalls the sequencer indefinitely. Only a low-to-high transition of bus_ready releases it.

## Configuration
- MUL_HILO_OVF_EN defined:
  - ovf port exists.
  - ovf is registered at capture: 1 when mul_p[63:31] is neither all-zeros nor all-ones, i.e. the product does not fit in 32 signed bits.
  - ovf holds until the next capture or clear.
- MUL_HILO_OVF_EN undefined: ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package mul_hilo_pkg:
  - State enum (IDLE, WAIT, WR_LO, WR_HI).
  - WORD_W=32, PROD_W=64.
  - Width of cnt (4 bits).
- One natural sub-module: hilo_reg_pair, the two 32-bit registers with load-enable and synchronous clear.
- The multiplier itself stays external and is connected through mul_m, mul_q and mul_p.

## Test plan
- 7 × -3 (op_b=0xFFFFFFFD), MUL_WAIT=2, bus_ready=1:
  - bus_out is 0xFFFFFFEB on the beat after E2, then 0xFFFFFFFF.
  - done pulses in the HI cycle.
  - ovf=0.
- 0x00010000 × 0x00010000:
  - lo=0x00000000, hi=0x00000001.
  - ovf=1 when enabled.
- 0x80000000 × 0x80000000: hi=0x40000000, lo=0, ovf=1.
- bus_ready low for 5 cycles in WR_LO:
  - bus_out stays 0xFFFFFFEB and bus_sel stays 0.
  - No advance until bus_ready rises.
  - start pulsed during the stall is ignored.
- clear asserted in WAIT:
  - Next cycle: all outputs at reset values and busy=0.
  - No done pulse.
  - A subsequent 2 × 3 produces lo=6, hi=0.
- Back-to-back: a second start in the first IDLE cycle is accepted. Its HI beat completes exactly MUL_WAIT+3 cycles after the first transaction's HI beat.
